wb_reg_responder: RTL and testbench
===================================

Name: wb_reg_responder

Overview:
- Wishbone B4 pipelined responder that terminates the register window (WB_REG_BASE = 3'b010) of the 20-bit system bus.
- Holds REG_CPU: bit0 READY, bit1 RESET.
- Drives the CPU ready and reset controls, and stretches CPU reset to a guaranteed minimum width.
- Sits beside the RAM responder on the bus driven by the SPI-to-Wishbone bridge; it is the target end of the wb_reg_addr() transactions.

Parameters:
- WB_ADDR_WIDTH, 20, bus address width.
- REG_ADDR_WIDTH, 1, register index width, taken from the low address bits.
- DATA_WIDTH, 8, bus data width.
- RESET_HOLD_CYCLES, 64, minimum cpu_reset_o assertion after any reset request (1 us at 64 MHz).

Ports:
- wb_clock_i  in  1  system clock, 64 MHz.
- wb_reset_n_i  in  1  asynchronous active-low reset.
- wb_addr_i  in  20  byte address.
- wb_data_i  in  8  write data.
- wb_data_o  out  8  read data, valid when wb_ack_o=1.
- wb_we_i  in  1  1 = write.
- wb_cycle_i  in  1  bus cycle active.
- wb_strobe_i  in  1  transfer request.
- wb_stall_o  out  1  responder cannot accept a request this cycle.
- wb_ack_o  out  1  transfer complete.
- cpu_ready_o  out  1  CPU RDY enable.
- cpu_reset_o  out  1  CPU reset, active-high.

Behaviour:
- Decode: select = wb_cycle_i & wb_strobe_i & ~wb_stall_o & (wb_addr_i[19:17] == 3'b010).
  - Register index = wb_addr_i[REG_ADDR_WIDTH-1:0].
  - Bits [16:REG_ADDR_WIDTH] are don't-care.
- Handshake FSM, states IDLE and ACK.
  - IDLE: on select, register we, index and data, then go to ACK. wb_stall_o=0.
  - ACK: wb_ack_o=1 for exactly one cycle, wb_stall_o=1, return to IDLE.
  - Result: one request per two cycles, ack latency exactly 1 cycle after acceptance.
- Strobe with a non-matching base: no ack, no state change. The RAM responder owns that address.
- Dropping wb_cycle_i in ACK aborts the transfer.
  - wb_ack_o is suppressed in that cycle.
  - A write accepted in IDLE has already taken effect.
- Writes take effect on the acceptance edge. Index 0 writes READY <= d[0] and RESET <= d[1]; d[7:2] are ignored.
- Reads: wb_data_o is registered in the ACK cycle.
  - Index 0 returns {5'b0, reset_active, RESET, READY}, where reset_active = cpu_reset_o.
  - Index >= REG_COUNT (1) reads 8'h00; writes to it are ignored.
  - wb_data_o = 8'h00 whenever wb_ack_o=0.
- cpu_ready_o = READY, registered.
- Reset stretcher (down-counter, width = $clog2(RESET_HOLD_CYCLES+1)):
  - Counter loads RESET_HOLD_CYCLES on every cycle that RESET=1.
  - Counter decrements to 0 when RESET=0, saturating at 0.
  - cpu_reset_o = RESET | (count != 0).
  - Clearing RESET N<RESET_HOLD_CYCLES cycles after setting it still holds cpu_reset_o high for RESET_HOLD_CYCLES cycles after the clear.
- Reset state (wb_reset_n_i=0, asynchronous):
  - FSM in IDLE, wb_ack_o=0, wb_stall_o=0, wb_data_o=0.
  - READY=0, RESET=1, count=RESET_HOLD_CYCLES.
  - Therefore cpu_ready_o=0 and cpu_reset_o=1.
  - The CPU stays held in reset until firmware writes RESET=0 and the hold expires.
- Reset asserted mid-transfer: the pending ack is dropped and no ack is issued after reset release.
- Simultaneous write of RESET=0 and counter expiry: the write has priority; the counter keeps decrementing from its value in that cycle.

Optional Feature:
- WB_REG_ERR_EN defined:
  - Adds port wb_err_o (out, 1).
  - An accepted request with index >= REG_COUNT completes with wb_err_o=1 and wb_ack_o=0 in the ACK cycle; wb_data_o=0.
  - wb_err_o resets to 0.
- WB_REG_ERR_EN undefined: no port; out-of-range index acks normally as described above.

Test Plan:
- Release reset, then idle 10 cycles -> cpu_reset_o=1, cpu_ready_o=0, no ack; read wb_reg_addr(0) -> ack 1 cycle after acceptance, data 8'h06.
- Write 8'h01 to addr 20'h40000 -> cpu_ready_o=1 next cycle; cpu_reset_o high exactly 64 more cycles after the write edge, then 0; readback 8'h01.
- Write RESET=1, then RESET=0 two requests later -> cpu_reset_o stays high 64 cycles after the clear; readback during hold = 8'h04.
- Strobe held every cycle to addr 20'h40000 -> wb_stall_o alternates 0/1, one ack per 2 cycles; strobe to 20'h00000 -> no ack, registers unchanged.
- Assert wb_reset_n_i in ACK state after a write of 8'h01 -> wb_ack_o=0 immediately; registers return to READY=0, RESET=1; no spurious ack after release.
- Index 1 (addr 20'h40001) read/write -> data 8'h00, REG_CPU unchanged; with WB_REG_ERR_EN, wb_err_o=1 for one cycle and wb_ack_o=0.

Source files
------------

// File: rtl/wb_reg_responder.sv
// Wishbone B4 pipelined responder for the register window holding REG_CPU (READY, RESET),
// with a reset stretcher on cpu_reset_o. Build macro WB_REG_ERR_EN adds wb_err_o for out-of-range indices.
//
// state   | meaning
// ST_IDLE | waiting for a request, wb_stall_o low
// ST_ACK  | completing the accepted request, wb_stall_o high
module wb_reg_responder #(
    parameter int WB_ADDR_WIDTH     = 20,
    parameter int REG_ADDR_WIDTH    = 1,
    parameter int DATA_WIDTH        = 8,
    parameter int RESET_HOLD_CYCLES = 64
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_n_i,
    input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cycle_i,
    input  logic                      wb_strobe_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
`ifdef WB_REG_ERR_EN
    output logic                      wb_err_o,
`endif
    output logic                      cpu_ready_o,
    output logic                      cpu_reset_o
);

    localparam logic [2:0] WB_REG_BASE = 3'b010;
    localparam int         REG_COUNT   = 1;
    localparam int         CNT_W       = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_t;

    state_t                    state;
    logic                      reg_reset;
    logic [CNT_W-1:0]          hold_cnt;
    logic                      ack_q;
    logic [DATA_WIDTH-1:0]     data_q;

    logic                      select;
    logic                      idx_valid;
    logic                      wr_cpu;
    logic                      reset_nxt;
    logic [REG_ADDR_WIDTH-1:0] req_idx;
    logic [CNT_W-1:0]          cnt_nxt;
    logic [DATA_WIDTH-1:0]     rd_cpu;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      unused_bits;

    assign select = wb_cycle_i & wb_strobe_i & ~wb_stall_o &
                    (wb_addr_i[WB_ADDR_WIDTH-1 -: 3] == WB_REG_BASE);

    assign req_idx   = wb_addr_i[REG_ADDR_WIDTH-1:0];
    assign idx_valid = ({{(32-REG_ADDR_WIDTH){1'b0}}, req_idx} < 32'(REG_COUNT));
    assign wr_cpu    = select & wb_we_i & idx_valid;
    assign reset_nxt = wr_cpu ? wb_data_i[1] : reg_reset;

    // Address bits between the base and the index, and data bits above RESET, carry no meaning.
    assign unused_bits = ^{wb_addr_i[WB_ADDR_WIDTH-4:REG_ADDR_WIDTH], wb_data_i[DATA_WIDTH-1:2]};

    // Stretcher reloads while RESET is held and counts out once it clears.
    always_comb begin
        cnt_nxt = '0;
        if (reg_reset) begin
            cnt_nxt = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            cnt_nxt = hold_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        rd_cpu    = '0;
        rd_cpu[0] = cpu_ready_o;
        rd_cpu[1] = reg_reset;
        rd_cpu[2] = cpu_reset_o;
    end

    always_comb begin
        rd_data = '0;
        if (!wb_we_i && idx_valid) begin
            rd_data = rd_cpu;
        end
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            cpu_ready_o <= 1'b0;
            reg_reset   <= 1'b1;
            hold_cnt    <= HOLD_LOAD;
            cpu_reset_o <= 1'b1;
        end else begin
            if (wr_cpu) begin
                cpu_ready_o <= wb_data_i[0];
            end
            reg_reset   <= reset_nxt;
            hold_cnt    <= cnt_nxt;
            cpu_reset_o <= reset_nxt | (cnt_nxt != '0);
        end
    end

`ifdef WB_REG_ERR_EN
    logic err_q;
`endif

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state      <= ST_IDLE;
            wb_stall_o <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
`ifdef WB_REG_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (select) begin
                        state      <= ST_ACK;
                        wb_stall_o <= 1'b1;
                        data_q     <= rd_data;
`ifdef WB_REG_ERR_EN
                        ack_q      <= idx_valid;
                        err_q      <= ~idx_valid;
`else
                        ack_q      <= 1'b1;
`endif
                    end
                end
                ST_ACK: begin
                    state      <= ST_IDLE;
                    wb_stall_o <= 1'b0;
                    ack_q      <= 1'b0;
                    data_q     <= '0;
`ifdef WB_REG_ERR_EN
                    err_q      <= 1'b0;
`endif
                end
                default: begin
                    state      <= ST_IDLE;
                    wb_stall_o <= 1'b0;
                    ack_q      <= 1'b0;
                    data_q     <= '0;
`ifdef WB_REG_ERR_EN
                    err_q      <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Dropping the cycle during ACK aborts the transfer, so the response is masked by wb_cycle_i.
    assign wb_ack_o  = ack_q & wb_cycle_i;
    assign wb_data_o = wb_ack_o ? data_q : '0;
`ifdef WB_REG_ERR_EN
    assign wb_err_o  = err_q & wb_cycle_i;
`endif

endmodule

// File: tb/tb_wb_reg_responder.sv
// Scoreboard bench for wb_reg_responder: tasks push expected responses, a negedge monitor pops and compares.
module tb_wb_reg_responder;

    localparam int HOLD = 64;
`ifdef WB_REG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ack;
        logic       err;
        logic [7:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [19:0] wb_addr = '0;
    logic [7:0]  wb_wdata = '0;
    logic [7:0]  wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_stall;
    logic        wb_ack;
    logic        wb_err;
    logic        cpu_ready;
    logic        cpu_reset;

    int tests = 0;
    int fails = 0;
    resp_t sb_q[$];
    resp_t mon_got;
    resp_t mon_exp;

    always #5 clk = ~clk;

    wb_reg_responder #(
        .WB_ADDR_WIDTH(20), .REG_ADDR_WIDTH(1), .DATA_WIDTH(8), .RESET_HOLD_CYCLES(HOLD)
    ) dut (
        .wb_clock_i  (clk),
        .wb_reset_n_i(rst_n),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_wdata),
        .wb_data_o   (wb_rdata),
        .wb_we_i     (wb_we),
        .wb_cycle_i  (wb_cyc),
        .wb_strobe_i (wb_stb),
        .wb_stall_o  (wb_stall),
        .wb_ack_o    (wb_ack),
`ifdef WB_REG_ERR_EN
        .wb_err_o    (wb_err),
`endif
        .cpu_ready_o (cpu_ready),
        .cpu_reset_o (cpu_reset)
    );

`ifndef WB_REG_ERR_EN
    assign wb_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t ok_resp(input logic [7:0] d);
        ok_resp = '{ack: 1'b1, err: 1'b0, data: d};
    endfunction

    function automatic resp_t oor_resp();
        oor_resp = ERR_EN ? '{ack: 1'b0, err: 1'b1, data: 8'h00} : '{ack: 1'b1, err: 1'b0, data: 8'h00};
    endfunction

    always @(negedge clk) begin
        if (wb_ack || wb_err) begin
            mon_got = '{ack: wb_ack, err: wb_err, data: wb_rdata};
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_resp: got 0x%0h with nothing expected at %0t", mon_got, $time);
            end else begin
                mon_exp = sb_q.pop_front();
                check("resp", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (wb_stall && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 10) check("stall_timeout", 32'(wb_stall), 32'd0);
    endtask

    task automatic wb_xfer(input logic [19:0] a, input logic we, input logic [7:0] d, input resp_t exp);
        @(posedge clk); #1;
        wait_idle();
        wb_addr = a; wb_we = we; wb_wdata = d;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        wb_stb = 1'b0;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
        check("ack_latency_pending", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wb_abort(input logic [19:0] a, input logic we, input logic [7:0] d);
        @(posedge clk); #1;
        wb_addr = a; wb_we = we; wb_wdata = d;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        check("abort_ack", 32'(wb_ack), 32'd0);
        check("abort_data", 32'(wb_rdata), 32'd0);
    endtask

    task automatic count_hold(input string name, input int exp_cycles);
        int n = 0;
        int guard = 0;
        while (cpu_reset && guard < 200) begin
            @(negedge clk);
            guard++;
            if (cpu_reset) n++;
        end
        check(name, 32'(n), 32'(exp_cycles));
        check({name, "_low"}, 32'(cpu_reset), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_stall", 32'(wb_stall), 32'd0);
        check("rst_data", 32'(wb_rdata), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        check("idle_cpu_ready", 32'(cpu_ready), 32'd0);
        check("idle_ack", 32'(wb_ack), 32'd0);

        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h06));

        // Release: READY=1, RESET=0; hold spans HOLD cycles from the write edge.
        wb_xfer(20'h40000, 1'b1, 8'h01, ok_resp(8'h00));
        check("ready_after_wr", 32'(cpu_ready), 32'd1);
        count_hold("hold_after_release", HOLD - 1);
        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h01));

        wb_xfer(20'h40000, 1'b1, 8'h02, ok_resp(8'h00));
        check("reset_set", 32'(cpu_reset), 32'd1);
        check("ready_cleared", 32'(cpu_ready), 32'd0);
        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h06));
        wb_xfer(20'h40000, 1'b1, 8'h00, ok_resp(8'h00));
        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h04));
        count_hold("hold_after_reclear", HOLD - 4);
        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h00));

        wb_xfer(20'h40000, 1'b1, 8'h01, ok_resp(8'h00));
        check("no_hold_when_clear", 32'(cpu_reset), 32'd0);

        // Back-to-back strobes: accepted every other cycle.
        @(posedge clk); #1;
        wb_addr = 20'h40000; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stream_stall", 32'(wb_stall), 32'(k % 2));
            if (k % 2 == 0) sb_q.push_back(ok_resp(8'h01));
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;

        @(posedge clk); #1;
        wb_addr = 20'h00000; wb_we = 1'b1; wb_wdata = 8'h02; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("foreign_ack", 32'(wb_ack), 32'd0);
            check("foreign_stall", 32'(wb_stall), 32'd0);
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("foreign_cpu_reset", 32'(cpu_reset), 32'd0);
        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h01));

        wb_abort(20'h40000, 1'b0, 8'h00);
        wb_abort(20'h40000, 1'b1, 8'h00);
        check("abort_write_took", 32'(cpu_ready), 32'd0);
        wb_xfer(20'h40000, 1'b1, 8'h01, ok_resp(8'h00));

        // Reset asserted while the write sits in ACK.
        @(posedge clk); #1;
        wb_addr = 20'h40000; wb_we = 1'b1; wb_wdata = 8'h01; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(wb_ack), 32'd0);
        check("midrst_stall", 32'(wb_stall), 32'd0);
        check("midrst_ready", 32'(cpu_ready), 32'd0);
        check("midrst_reset", 32'(cpu_reset), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_ack", 32'(wb_ack), 32'd0);
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
        wb_xfer(20'h40000, 1'b0, 8'h00, ok_resp(8'h06));

        wb_xfer(20'h40000, 1'b1, 8'h00, ok_resp(8'h00));
        count_hold("hold_before_idx1", HOLD - 1);
        wb_xfer(20'h40001, 1'b1, 8'h03, oor_resp());
        wb_xfer(20'h40001, 1'b0, 8'h00, oor_resp());
        check("idx1_ready", 32'(cpu_ready), 32'd0);
        check("idx1_reset", 32'(cpu_reset), 32'd0);
        wb_xfer(20'h5FFFE, 1'b0, 8'h00, ok_resp(8'h00));

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
